rom_scan_ctrl: RTL
==================

# rom_scan_ctrl

Parametrised ROM browser controller that sits between the key_filter instances and a synchronous ROM IP, and drives the seg_595_dynamic data bus. It generalises a two-key address stepper:
- configurable depth, address width and data width;
- four run modes: auto-up, auto-down, manual, hold;
- wrap-around at a non-power-of-two depth;
- ROM read-latency tracking, so downstream logic sees only settled data.

## Interface

Parameters:
- DEPTH, 256: number of valid ROM words; addresses run 0..DEPTH-1; legal range 2..2**ADDR_W.
- ADDR_W, 8: ROM address width.
- DATA_W, 8: ROM word width.
- CNT_MAX, 24'd9_999_999: auto-step interval in clocks, minus 1.
- ROM_LAT, 2: ROM read latency in clocks, from address to q; legal range 1..3.

Ports (clock and reset first):
- sys_clk, in, 1: system clock; the only clock in the block.
- sys_rst_n, in, 1: asynchronous, active-low reset.
- key_next_flag, in, 1: one-cycle pulse from key_filter; steps +1 in manual mode.
- key_prev_flag, in, 1: one-cycle pulse; steps -1 in manual mode.
- key_mode_flag, in, 1: one-cycle pulse; advances the run mode.
- rom_q, in, DATA_W: ROM output data.
- rom_addr, out, ADDR_W: registered ROM address.
- data_out, out, DATA_W: last settled ROM word.
- data_valid, out, 1: data_out corresponds to the current rom_addr.
- mode, out, 2: current run mode.

## Operation

- Mode register, 2 bits: UP=0, DOWN=1, MANUAL=2, HOLD=3.
  - key_mode_flag advances UP→DOWN→MANUAL→HOLD→UP.
- Step timer:
  - In UP and DOWN, counts 0..CNT_MAX; tick is asserted on the cycle cnt==CNT_MAX, then cnt returns to 0.
  - In MANUAL and HOLD, cnt is held at 0.
  - A mode change clears cnt.
- Address update, registered:
  - UP: tick → rom_addr+1; DEPTH-1 wraps to 0.
  - DOWN: tick → rom_addr-1; 0 wraps to DEPTH-1.
  - MANUAL: key_next_flag → +1, key_prev_flag → -1, same wrap rules; both flags in one cycle → no change.
  - HOLD: rom_addr frozen; next and prev flags ignored.
  - UP and DOWN ignore next and prev flags.
- Simultaneous events:
  - key_mode_flag and tick in the same cycle: the mode change wins, no step occurs, and cnt clears.
  - key_mode_flag with next or prev: the mode changes and next/prev are ignored.
- Wrap arithmetic:
  - Compare explicitly against DEPTH-1 and 0; never rely on natural ADDR_W overflow.
  - rom_addr never exceeds DEPTH-1.
- Latency tracker:
  - A counter of width $clog2(ROM_LAT+2) reloads to 0 on every address change and increments, saturating, to ROM_LAT.
  - While the count is below ROM_LAT, data_valid=0 and data_out holds its previous value.
  - Once the count reaches ROM_LAT, data_out <= rom_q every clock and data_valid=1.

## Timing

- Reset values:
  - rom_addr=0, mode=UP, cnt=0, data_out=0, data_valid=0.
  - Latency counter=0, so reset behaves as an address change.
- Step timing: a tick or key pulse at edge N changes rom_addr at edge N+1.
- Data settling: after rom_addr changes at edge E:
  - data_valid stays low through edge E+ROM_LAT;
  - at edge E+ROM_LAT+1, data_out takes the new word and data_valid=1.
- Auto-step period: exactly CNT_MAX+1 clocks between rom_addr changes.
- Fast stepping: if steps arrive faster than ROM_LAT+1 clocks apart (only possible in manual mode with a small key_filter CNT_MAX):
  - each change restarts the tracker;
  - data_valid never presents a stale word as valid.
- Reset asserted mid-operation: all registers return asynchronously to their reset values; no partial step completes.

## Structure

- Shared package rom_scan_pkg:
  - mode encodings MODE_UP, MODE_DOWN, MODE_MANUAL, MODE_HOLD;
  - the mode typedef (2-bit);
  - the next-mode function.
- Sub-module rom_step_timer, parameter CNT_MAX:
  - inputs: sys_clk, sys_rst_n, en, clr;
  - output: tick.
  - Reused by later auto-scanning display blocks.
- Address, mode and latency logic stay in the top module.
- The ROM itself stays outside the block; the top-level design instantiates rom_8x256 and wires rom_addr/rom_q.

## Test plan

Bench setup for all scenarios: DEPTH=10, ADDR_W=4, CNT_MAX=9, ROM_LAT=2; the ROM model returns q=addr+8'h30.

- Reset release → rom_addr=0, mode=0, data_valid=0 for 2 clocks; on the 3rd edge data_out=8'h30 and data_valid=1.
- UP mode, free-running → rom_addr steps every 10 clocks, 0,1,…,9,0; data_out follows 3 clocks after each step.
- One mode pulse (DOWN) from rom_addr=0 → the next tick gives rom_addr=9 and data_out=8'h39; no step occurs in the pulse cycle.
- Mode pulse coincident with a tick → mode changes, rom_addr unchanged, the next tick arrives exactly 10 clocks later.
- MANUAL mode:
  - next pulses at rom_addr=9 → 0;
  - prev at 0 → 9;
  - next and prev in the same cycle → no change;
  - next pulses 1 clock apart → data_valid stays 0 until 3 clocks after the last pulse.
- HOLD mode → next/prev ignored and rom_addr stable for 50 clocks. Reset asserted mid-hold → rom_addr=0, mode=UP and data_valid=0 immediately.

Source files
------------

// File: rtl/rom_scan_pkg.sv
// Shared mode encodings and mode sequencing for the ROM scan controller family.
package rom_scan_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_MANUAL = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    // Mode key cycles UP -> DOWN -> MANUAL -> HOLD -> UP.
    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            MODE_UP:     r = MODE_DOWN;
            MODE_DOWN:   r = MODE_MANUAL;
            MODE_MANUAL: r = MODE_HOLD;
            default:     r = MODE_UP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rom_step_timer.sv
// Free-running step timer: tick asserts for one cycle every CNT_MAX+1 enabled clocks.
module rom_step_timer #(
    parameter int unsigned CNT_MAX = 24'd9_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter sits at zero whenever disabled so re-enabling always gives a full period.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || !en || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/rom_scan_ctrl.sv
// ROM browser: steps a wrapping address by timer or keys, and presents ROM data
// only once it has settled through the ROM read latency.
module rom_scan_ctrl
    import rom_scan_pkg::*;
#(
    parameter int          DEPTH   = 256,
    parameter int          ADDR_W  = 8,
    parameter int          DATA_W  = 8,
    parameter int unsigned CNT_MAX = 24'd9_999_999,
    parameter int          ROM_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              key_next_flag,
    input  logic              key_prev_flag,
    input  logic              key_mode_flag,
    input  logic [DATA_W-1:0] rom_q,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [1:0]        mode
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam int LW = $clog2(ROM_LAT + 2);
    localparam logic [LW-1:0] LAT_MAX = LW'(ROM_LAT);

    // Handshake: the key flags are single-cycle strobes with no back-pressure;
    // data_valid qualifies data_out against the current rom_addr, not a transfer.

    mode_t             mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              tick, step_up, step_dn, addr_chg, lat_done, auto_en;

    assign auto_en = (mode_q == MODE_UP) || (mode_q == MODE_DOWN);

    rom_step_timer #(
        .CNT_MAX (CNT_MAX)
    ) u_step_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (auto_en),
        .clr       (key_mode_flag),
        .tick      (tick)
    );

    // A mode pulse suppresses any step requested in the same cycle.
    always_comb begin
        mode_d  = mode_q;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (key_mode_flag) begin
            mode_d = next_mode(mode_q);
        end else begin
            case (mode_q)
                MODE_UP:     step_up = tick;
                MODE_DOWN:   step_dn = tick;
                MODE_MANUAL: begin
                    step_up = key_next_flag & ~key_prev_flag;
                    step_dn = key_prev_flag & ~key_next_flag;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (step_up) begin
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
        end else if (step_dn) begin
            addr_d = (addr_q == '0) ? ADDR_LAST : addr_q - ADDR_W'(1);
        end
    end

    assign addr_chg = step_up | step_dn;
    assign lat_done = (lat_q == LAT_MAX);

    // Valid drops on the edge the address moves, even if the old word was just captured.
    always_comb begin
        lat_d   = lat_done ? lat_q : lat_q + LW'(1);
        data_d  = lat_done ? rom_q : data_q;
        valid_d = lat_done & ~addr_chg;
        if (addr_chg) begin
            lat_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q  <= MODE_UP;
            addr_q  <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rom_addr   = addr_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign mode       = mode_q;

endmodule
